// File: rtl/cla_pkg.sv
// Shared definitions for the sequential CLA add/subtract unit: FSM encoding,
// nibble width and the nibble carry-out helper used to chain the slice carry.
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   function automatic logic nibbleCarry(input logic pg, input logic gg, input logic cin);
      return gg | (pg & cin);
   endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// Single 4-bit carry-lookahead slice; exports group propagate/generate so the
// caller can chain the carry between nibbles through a register.
module CLA_4bit (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_pg,
   output logic       o_gg
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Internal carries are fully expanded so no bit waits on its neighbour.
   assign w_c[0] = i_cin;
   assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_cin);

   assign o_sum = w_p ^ w_c;
   assign o_pg  = &w_p;
   assign o_gg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Iterative WIDTH-bit add/subtract that reuses one CLA_4bit slice, one nibble
// per cycle LSB first, with valid/ready handshakes on request and result.
module cla_seq_adder_ctrl
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   input  logic             Cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = $clog2(NIBBLES);
   localparam int BASE_W  = IDX_W + $clog2(NIBBLE_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_sum;
   logic                 r_carry;
   logic                 r_cout;
   logic                 r_ovf;
   logic [IDX_W-1:0]     r_idx;
   logic [BASE_W-1:0]    w_base;
   logic [NIBBLE_W-1:0]  w_sliceSum;
   logic                 w_pg;
   logic                 w_gg;
   logic                 w_carryOut;
   logic                 w_accept;
   logic                 w_last;

   assign w_base     = {r_idx, {$clog2(NIBBLE_W){1'b0}}};
   assign w_carryOut = nibbleCarry(w_pg, w_gg, r_carry);
   assign w_accept   = req_valid & req_ready;
   assign w_last     = (r_idx == LAST_IDX);

   CLA_4bit u_slice (
      .i_a   (r_a[w_base +: NIBBLE_W]),
      .i_b   (r_b[w_base +: NIBBLE_W]),
      .i_cin (r_carry),
      .o_sum (w_sliceSum),
      .o_pg  (w_pg),
      .o_gg  (w_gg)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // req_ready is gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid && rst_n) w_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Subtraction is folded in at accept: B is inverted and the carry seeded with 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= A;
         r_b     <= B ^ {WIDTH{sub}};
         r_carry <= sub ? 1'b1 : Cin;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (r_state == RUN) begin
         r_sum[w_base +: NIBBLE_W] <= w_sliceSum;
         r_carry <= w_carryOut;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            r_cout <= w_carryOut;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_sliceSum[NIBBLE_W-1] != r_a[WIDTH-1]);
         end
      end
   end

   assign Sum  = r_sum;
   assign Cout = r_cout;
   assign Ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops and compares on every result handshake.
module tb_cla_seq_adder_ctrl;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        sub;
   logic        Cin;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] Sum;
   logic        Cout;
   logic        Ovf;
   logic        busy;

   exp_t scb[$];
   int   compares   = 0;
   int   mismatches = 0;

   cla_seq_adder_ctrl #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .Cin       (Cin),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .Ovf       (Ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compares++;
      if (act !== exp) begin
         mismatches++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a result handshake completes on the posedge after this negedge.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (scb.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = scb.pop_front();
            checkOutput("sum",  Sum, e.sum);
            checkOutput("cout", {31'd0, Cout}, {31'd0, e.cout});
            checkOutput("ovf",  {31'd0, Ovf},  {31'd0, e.ovf});
         end
      end
   end

   // Presents a request, waits for acceptance, then scrambles the operands.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input logic c, input logic [31:0] eSum, input logic eCout,
                                input logic eOvf, input bit expectResult);
      int bound;
      @(posedge clk); #1;
      req_valid = 1'b1; A = a; B = b; sub = s; Cin = c;
      bound = 0;
      @(negedge clk);
      while (!req_ready && bound < 100) begin
         @(negedge clk);
         bound++;
      end
      if (!req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
      if (expectResult) scb.push_back('{sum: eSum, cout: eCout, ovf: eOvf});
      @(posedge clk); #1;
      req_valid = 1'b0; A = $urandom; B = $urandom; sub = 1'($urandom); Cin = 1'($urandom);
   endtask

   task automatic waitResult(input string name);
      int cycles;
      cycles = 0;
      while (!res_valid && cycles < 50) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput(name, cycles, 32'd8);
   endtask

   task automatic drainResult();
      int bound;
      bound = 0;
      while (res_valid && bound < 50) begin
         @(posedge clk); #1;
         bound++;
      end
   endtask

   task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input logic [31:0] eSum,
                        input logic eCout, input logic eOvf);
      applyStimulus(a, b, s, c, eSum, eCout, eOvf, 1'b1);
      waitResult(name);
      drainResult();
   endtask

   initial begin
      int bound;
      rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
      A = '0; B = '0; sub = 1'b0; Cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("rst_busy",      {31'd0, busy},      32'd0);
      checkOutput("rst_sum",       Sum,                32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);

      runOp("lat_add",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
      runOp("lat_chain",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      runOp("lat_sub",      32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b0, 1'b0);
      runOp("lat_sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      runOp("lat_cin_add",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      runOp("lat_cin_sub",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

      // Backpressure: result must hold and a waiting request must not be taken.
      res_ready = 1'b0;
      applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
      waitResult("lat_bp");
      req_valid = 1'b1; A = 32'h7000_0000; B = 32'h1000_0000; sub = 1'b0; Cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_res_valid", {31'd0, res_valid}, 32'd1);
         checkOutput("bp_sum",       Sum,                32'h2345_6789);
         checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      applyStimulus(32'h7000_0000, 32'h1000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
      waitResult("lat_after_bp");
      drainResult();

      // Abort mid-RUN at idx 3; no result may ever appear afterwards.
      applyStimulus(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("abort_busy",      {31'd0, busy},      32'd0);
      checkOutput("abort_sum",       Sum,                32'd0);
      checkOutput("abort_cout",      {31'd0, Cout},      32'd0);
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         checkOutput("abort_no_result", {31'd0, res_valid}, 32'd0);
      end
      checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);

      runOp("lat_post_abort", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      bound = 0;
      while (scb.size() != 0 && bound < 50) begin
         @(posedge clk);
         bound++;
      end
      checkOutput("scoreboard_empty", scb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule
